// File: rtl/adder_tree_operand_loader_if.sv
// Stream-in / bundle-out interface of the adder tree operand loader.
// master = word producer and bundle consumer; slave = the loader itself.
interface adder_tree_operand_loader_if #(
    parameter int ADDER_WIDTH  = 14,
    parameter int NUM_OPERANDS = 8
);
    logic [ADDER_WIDTH-1:0]              in_data;
    logic                                in_valid;
    logic                                in_last;
    logic                                in_ready;
    logic [NUM_OPERANDS*ADDER_WIDTH-1:0] out_operands;
    logic [$clog2(NUM_OPERANDS):0]       out_count;
    logic                                out_valid;
    logic                                out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_operands, out_count, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_operands, out_count, out_valid
    );
endinterface

// File: rtl/adder_tree_operand_loader.sv
// Serial-to-parallel loader packing stream words into NUM_OPERANDS held lanes.
// Optional early frame termination with zero fill: ADDER_TREE_LOADER_ZERO_FILL_EN.
module adder_tree_operand_loader #(
    parameter int ADDER_WIDTH  = 14,
    parameter int NUM_OPERANDS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    adder_tree_operand_loader_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_OPERANDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

`ifdef ADDER_TREE_LOADER_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    typedef enum logic [1:0] {
        INIT,
        FILL,
        HOLD
    } state_e;

    state_e                              state_q;
    logic [IDX_W-1:0]                    idx_q;
    logic                                in_ready_q;
    logic                                out_valid_q;
    logic [CNT_W-1:0]                    count_q;
    logic [NUM_OPERANDS*ADDER_WIDTH-1:0] operands_q;
    logic [NUM_OPERANDS*ADDER_WIDTH-1:0] operands_d;
    logic                                accept;
    logic                                early_last;
    logic                                frame_done;

    always_comb begin
        accept     = in_ready_q && bus.in_valid;
        early_last = ZERO_FILL && bus.in_last;
        frame_done = (idx_q == LAST_IDX) || early_last;
    end

    // Lanes above idx are cleared only when a short frame terminates here.
    always_comb begin
        operands_d = operands_q;
        for (int unsigned j = 0; j < NUM_OPERANDS; j++) begin
            if (IDX_W'(j) == idx_q) begin
                operands_d[j*ADDER_WIDTH +: ADDER_WIDTH] = bus.in_data;
            end else if (early_last && (IDX_W'(j) > idx_q)) begin
                operands_d[j*ADDER_WIDTH +: ADDER_WIDTH] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            operands_q  <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    state_q    <= FILL;
                    in_ready_q <= 1'b1;
                end
                FILL: begin
                    if (accept) begin
                        operands_q <= operands_d;
                        if (frame_done) begin
                            count_q     <= CNT_W'(idx_q) + CNT_W'(1);
                            idx_q       <= '0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                default: begin
                    state_q     <= INIT;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_count    = count_q;
    assign bus.out_operands = operands_q;
endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// Self-checking bench for adder_tree_operand_loader against a frame-level queue model.
// Follows ADDER_TREE_LOADER_ZERO_FILL_EN the same way the design does.
module tb_adder_tree_operand_loader;
    localparam int W  = 14;
    localparam int N  = 8;
    localparam int CW = $clog2(N) + 1;

`ifdef ADDER_TREE_LOADER_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_tree_operand_loader_if #(.ADDER_WIDTH(W), .NUM_OPERANDS(N)) bus ();

    adder_tree_operand_loader #(.ADDER_WIDTH(W), .NUM_OPERANDS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks;
    int unsigned n_pass;

    // Frame-level model: accepted words collect in a queue until the frame closes.
    logic [W-1:0] m_lanes [N];
    logic [W-1:0] m_words [$];
    int unsigned  m_count;
    bit           m_init, m_ready, m_valid;

    function automatic void m_reset();
        m_init  = 1'b1;
        m_ready = 1'b0;
        m_valid = 1'b0;
        m_count = 0;
        m_words.delete();
        for (int k = 0; k < N; k++) m_lanes[k] = '0;
    endfunction

    function automatic logic [N*W-1:0] m_packed();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = m_lanes[k];
        return r;
    endfunction

    // One clock edge; the model sees the same inputs the DUT samples.
    task automatic tick();
        logic         v, l, r;
        logic [W-1:0] d;
        v = bus.in_valid; l = bus.in_last; r = bus.out_ready; d = bus.in_data;
        @(posedge clk);
        if (rst_n) begin
            if (m_init) begin
                m_init  = 1'b0;
                m_ready = 1'b1;
            end else if (m_ready && v) begin
                m_words.push_back(d);
                if (m_words.size() == N || (ZF && l)) begin
                    for (int k = 0; k < N; k++) begin
                        if (k < m_words.size()) m_lanes[k] = m_words[k];
                        else if (ZF && l)       m_lanes[k] = '0;
                    end
                    m_count = m_words.size();
                    m_words.delete();
                    m_ready = 1'b0;
                    m_valid = 1'b1;
                end
            end else if (m_valid && r) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_operands !== '0 || bus.out_count !== '0)
            $display("FAIL reset_values ready=%b valid=%b ops=%h cnt=%0d required 0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.out_operands, bus.out_count);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL reset_release ready=%b valid=%b required 1/0", bus.in_ready, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [N*W-1:0] exp_ops, seen_ops;
        logic [CW-1:0]  seen_cnt;
        int unsigned    vcyc = 0, nrcyc = 0;
        for (int k = 0; k < N; k++) exp_ops[k*W +: W] = W'(k + 1);
        seen_ops = '0; seen_cnt = '0;
        bus.out_ready = 1'b1;
        bus.in_last   = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            bus.in_valid = (i < N);
            bus.in_data  = W'(i + 1);
            tick();
            n_checks++;
            if (bus.in_ready !== m_ready || bus.out_valid !== m_valid)
                $display("FAIL basic_hs cyc=%0d ready=%b valid=%b required %b/%b",
                         i, bus.in_ready, bus.out_valid, m_ready, m_valid);
            else n_pass++;
            if (bus.out_valid === 1'b1) begin
                vcyc++; seen_ops = bus.out_operands; seen_cnt = bus.out_count;
            end
            if (bus.in_ready !== 1'b1) nrcyc++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (seen_ops !== exp_ops || seen_cnt !== CW'(N))
            $display("FAIL basic_bundle ops=%h cnt=%0d required %h/%0d", seen_ops, seen_cnt, exp_ops, N);
        else n_pass++;
        n_checks++;
        if (vcyc != 1 || nrcyc != 1)
            $display("FAIL basic_pulse valid_cycles=%0d notready_cycles=%0d required 1/1", vcyc, nrcyc);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] exp_ops;
        for (int k = 0; k < N; k++) exp_ops[k*W +: W] = W'(14'h3FFF);
        bus.out_ready = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = W'(14'h3FFF);
        repeat (N) tick();
        for (int i = 0; i < 5; i++) begin
            bus.in_data = W'($urandom);
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_operands !== exp_ops || bus.out_count !== CW'(N))
                $display("FAIL backpressure_hold cyc=%0d valid=%b ready=%b ops=%h cnt=%0d required 1/0/%h/%0d",
                         i, bus.out_valid, bus.in_ready, bus.out_operands, bus.out_count, exp_ops, N);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || m_ready !== 1'b1)
            $display("FAIL backpressure_release ready=%b valid=%b required 1/0", bus.in_ready, bus.out_valid);
        else n_pass++;
        // A fresh frame proves none of the stalled words slipped in.
        bus.in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.in_data = W'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_operands !== m_packed())
            $display("FAIL backpressure_next valid=%b ops=%h required 1/%h",
                     bus.out_valid, bus.out_operands, m_packed());
        else n_pass++;
        tick();
    endtask

    task automatic test_gaps();
        logic [N*W-1:0] exp_ops, seen_ops;
        bit             seen = 1'b0;
        for (int k = 0; k < N; k++) exp_ops[k*W +: W] = W'(10 + k);
        seen_ops = '0;
        bus.out_ready = 1'b1;
        bus.in_last   = 1'b0;
        for (int i = 0; i < 2 * N + 2; i++) begin
            bus.in_valid = (i % 2 == 0) && (i < 2 * N);
            bus.in_data  = bus.in_valid ? W'(10 + i / 2) : W'($urandom);
            tick();
            n_checks++;
            if (bus.in_ready !== m_ready || bus.out_valid !== m_valid)
                $display("FAIL gaps_hs cyc=%0d ready=%b valid=%b required %b/%b",
                         i, bus.in_ready, bus.out_valid, m_ready, m_valid);
            else n_pass++;
            if (bus.out_valid === 1'b1) begin seen = 1'b1; seen_ops = bus.out_operands; end
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (!seen || seen_ops !== exp_ops)
            $display("FAIL gaps_bundle seen=%b ops=%h required 1/%h", seen, seen_ops, exp_ops);
        else n_pass++;
    endtask

    task automatic test_short_frame();
        logic [N*W-1:0] exp_ops;
        bus.out_ready = 1'b1;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = W'(14'h1111);
        repeat (N) tick();
        bus.in_valid = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = W'(5 + i);
            bus.in_last = (i == 2);
            tick();
        end
        bus.in_last = 1'b0;
`ifdef ADDER_TREE_LOADER_ZERO_FILL_EN
        bus.in_valid = 1'b0;
        exp_ops = '0;
        for (int k = 0; k < 3; k++) exp_ops[k*W +: W] = W'(5 + k);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_operands !== exp_ops || bus.out_count !== CW'(3))
            $display("FAIL short_frame valid=%b ops=%h cnt=%0d required 1/%h/3",
                     bus.out_valid, bus.out_operands, bus.out_count, exp_ops);
        else n_pass++;
`else
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL short_ignored valid=%b ready=%b required 0/1", bus.out_valid, bus.in_ready);
        else n_pass++;
        exp_ops = '0;
        for (int k = 0; k < 3; k++) exp_ops[k*W +: W] = W'(5 + k);
        for (int i = 3; i < N; i++) begin
            bus.in_data = W'($urandom);
            bus.in_last = ($urandom_range(0, 1) == 1);
            exp_ops[i*W +: W] = bus.in_data;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_operands !== exp_ops || bus.out_count !== CW'(N))
            $display("FAIL short_full valid=%b ops=%h cnt=%0d required 1/%h/%0d",
                     bus.out_valid, bus.out_operands, bus.out_count, exp_ops, N);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_reset_midframe();
        logic [N*W-1:0] exp_ops;
        bus.out_ready = 1'b1;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = W'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_operands !== '0 || bus.out_count !== '0)
            $display("FAIL midframe_reset ready=%b valid=%b ops=%h cnt=%0d required 0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.out_operands, bus.out_count);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL midframe_release ready=%b required 1", bus.in_ready);
        else n_pass++;
        for (int k = 0; k < N; k++) exp_ops[k*W +: W] = W'(16'h100 + k);
        bus.in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.in_data = W'(16'h100 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_operands !== exp_ops || bus.out_count !== CW'(N))
            $display("FAIL midframe_reload valid=%b ops=%h cnt=%0d required 1/%h/%0d",
                     bus.out_valid, bus.out_operands, bus.out_count, exp_ops, N);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int unsigned bundles = 0;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = W'($urandom);
            bus.in_last   = ($urandom_range(0, 3) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
            n_checks++;
            if (bus.in_ready !== m_ready || bus.out_valid !== m_valid)
                $display("FAIL random_hs cyc=%0d ready=%b valid=%b required %b/%b",
                         i, bus.in_ready, bus.out_valid, m_ready, m_valid);
            else n_pass++;
            if (m_valid) begin
                bundles++;
                n_checks++;
                if (bus.out_operands !== m_packed() || bus.out_count !== CW'(m_count))
                    $display("FAIL random_bundle cyc=%0d ops=%h cnt=%0d required %h/%0d",
                             i, bus.out_operands, bus.out_count, m_packed(), m_count);
                else n_pass++;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_checks++;
        if (bundles == 0)
            $display("FAIL random_progress bundles=%0d required >0", bundles);
        else n_pass++;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        m_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_short_frame();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/adder_tree_operand_loader.md
# adder_tree_operand_loader

Serial-to-parallel operand loader that feeds the adder tree benchmarks. It accepts one ADDER_WIDTH-bit word per cycle over a valid/ready stream and packs words into NUM_OPERANDS parallel lanes. Each complete frame is presented as one held bundle, with its own valid/ready handshake, to the tree's leaf operand inputs. It is the producer end of the tree's operand interface; the tree reduces lanes, this block populates them.

## Interface
- ADDER_WIDTH, default 14: width of each operand word/lane.
- NUM_OPERANDS, default 8: lanes per frame; power of two, ≥2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  ADDER_WIDTH  operand word.
- in_valid  input  1  in_data valid.
- in_last  input  1  final word of a short frame (see Configuration).
- in_ready  output  1  loader can accept a word this cycle; registered.
- out_operands  output  NUM_OPERANDS*ADDER_WIDTH  lane k at bits [k*ADDER_WIDTH +: ADDER_WIDTH]; lane 0 drives isum0_0_0_0, lane 7 drives isum0_1_1_1.
- out_count  output  $clog2(NUM_OPERANDS)+1  number of loaded lanes in the frame (1..NUM_OPERANDS).
- out_valid  output  1  bundle valid; registered.
- out_ready  input  1  downstream consumed bundle.

## Operation
- States: INIT, FILL, HOLD. Lane index idx counts 0..NUM_OPERANDS-1.
- INIT: entered on reset; in_ready=0, out_valid=0. Unconditionally goes to FILL on the next edge.
- FILL: in_ready=1. On accept (in_valid && in_ready), in_data is written to lane idx, and idx increments.
- Frame completes on accepting the word at idx==NUM_OPERANDS-1, or on accept with in_last=1 when zero-fill is enabled.
- On completion: set out_count=idx+1, reset idx to 0, and go to HOLD.
- HOLD: in_ready=0, out_valid=1; out_operands and out_count are frozen.
- On out_valid && out_ready, return to FILL. Lanes keep their old values until overwritten.
- in_valid is ignored while in_ready=0; no word is ever dropped or duplicated.
- Simultaneous in_last and idx==NUM_OPERANDS-1 is a normal full frame: out_count=NUM_OPERANDS.
- Reset mid-frame (asserting rst_n low) discards the partial frame and any held bundle.

## Timing
- Reset values: in_ready=0, out_valid=0, out_operands=0, out_count=0, idx=0, state=INIT.
- First rising edge after rst_n deasserts: in_ready=1.
- Latency: out_valid rises on the edge that accepts the completing word; the bundle is visible the following cycle.
- in_ready falls on that same edge.
- out_ready seen high in HOLD: out_valid=0 and in_ready=1 on the next edge.
- Minimum frame period: NUM_OPERANDS+1 cycles (full frame, out_ready tied high).
- No combinational path from any input to any output.

## Configuration
- Macro: ADDER_TREE_LOADER_ZERO_FILL_EN.
- Defined:
  - in_last terminates a frame early.
  - On accepting a word at idx=k with in_last=1, lanes k+1..NUM_OPERANDS-1 are cleared to 0 on the same edge.
  - out_count=k+1.
- Undefined:
  - in_last is ignored.
  - Every frame is exactly NUM_OPERANDS words, and out_count always equals NUM_OPERANDS.

## Test plan
- Reset release then 8 words 1..8, with in_valid and out_ready held high → one bundle with lanes 0..7 = 1..8 and out_count=8. out_valid is high for exactly 1 cycle; in_ready is low for that cycle.
- Backpressure: out_ready=0 for 5 cycles after a full frame of 0x3FFF. Required: out_valid and the lanes stay stable, in_ready stays 0, and a concurrent in_valid is not accepted. Releasing out_ready → in_ready=1 on the next cycle.
- in_valid toggled every other cycle with words 10..17 → lanes 0..7 = 10..17; gaps cause no skips.
- With ZERO_FILL_EN defined: send 3 words 5,6,7 with in_last on the third, following a previous frame of all 0x1111 → lanes = 5,6,7,0,0,0,0,0 and out_count=3. Without the macro, the same stimulus waits for 5 more words.
- Reset asserted after 4 of 8 words → all outputs return to reset values. The next 8 words, 0x100..0x107, load lanes 0..7 correctly.
